// File: rtl/tpu_pkg.sv
// Shared definitions for the systolic array sequencer: state encoding,
// operand-select codes and the skewed feed schedule.
package tpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_DRAIN,
    ST_CAPTURE
  } state_t;

  localparam logic [1:0] SEL_OP0  = 2'd0;
  localparam logic [1:0] SEL_OP1  = 2'd1;
  localparam logic [1:0] SEL_ZERO = 2'd2;

  localparam int FEED_STEPS = 3;

  typedef struct packed {
    logic [1:0] a0;
    logic [1:0] a1;
    logic [1:0] b0;
    logic [1:0] b1;
  } sel_t;

  localparam sel_t SEL_ALL_ZERO = '{SEL_ZERO, SEL_ZERO, SEL_ZERO, SEL_ZERO};

  // Row/column 1 lag row/column 0 by one step to form the diagonal wavefront.
  function automatic sel_t feed_sel(input logic [1:0] step);
    sel_t s;
    s = SEL_ALL_ZERO;
    case (step)
      2'd0: s = '{SEL_OP0,  SEL_ZERO, SEL_OP0,  SEL_ZERO};
      2'd1: s = '{SEL_OP1,  SEL_OP0,  SEL_OP1,  SEL_OP0};
      2'd2: s = '{SEL_ZERO, SEL_OP1,  SEL_ZERO, SEL_OP1};
      default: s = SEL_ALL_ZERO;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/systolic_controller.sv
// Sequencer for the 2x2 systolic array: clear / feed / drain / capture
// schedule driven by a one-cycle start, with result holding registers.
module systolic_controller
  import tpu_pkg::*;
#(
  parameter int ACC_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        transpose_in,
  input  logic                        activation_in,
  input  logic                        accumulate,
  output logic                        busy,
  output logic                        done,
  output logic [1:0]                  a0_sel,
  output logic [1:0]                  a1_sel,
  output logic [1:0]                  b0_sel,
  output logic [1:0]                  b1_sel,
  output logic                        clear,
  output logic                        transpose,
  output logic                        activation,
  input  logic signed [ACC_WIDTH-1:0] c00_in,
  input  logic signed [ACC_WIDTH-1:0] c01_in,
  input  logic signed [ACC_WIDTH-1:0] c10_in,
  input  logic signed [ACC_WIDTH-1:0] c11_in,
  output logic signed [ACC_WIDTH-1:0] result00,
  output logic signed [ACC_WIDTH-1:0] result01,
  output logic signed [ACC_WIDTH-1:0] result10,
  output logic signed [ACC_WIDTH-1:0] result11,
  output logic                        result_valid
);

  localparam logic [1:0] LAST_STEP = 2'(FEED_STEPS - 1);

  state_t                      r_state, w_next;
  logic [1:0]                  r_step;
  logic                        r_transpose, r_activation, r_accum;
  logic                        r_done, r_valid;
  logic signed [ACC_WIDTH-1:0] r_res00, r_res01, r_res10, r_res11;
  logic                        w_accept;
  sel_t                        w_sel;

  assign w_accept = start && (r_state == ST_IDLE);

  // State register plus step counter and latched command fields
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_step       <= 2'd0;
      r_transpose  <= 1'b0;
      r_activation <= 1'b0;
      r_accum      <= 1'b0;
      r_done       <= 1'b0;
      r_valid      <= 1'b0;
      r_res00      <= '0;
      r_res01      <= '0;
      r_res10      <= '0;
      r_res11      <= '0;
    end else begin
      r_state <= w_next;
      r_step  <= (r_state == ST_FEED) ? r_step + 2'd1 : 2'd0;
      r_done  <= (r_state == ST_CAPTURE);
      if (w_accept) begin
        r_transpose  <= transpose_in;
        r_activation <= activation_in;
        r_accum      <= accumulate;
        r_valid      <= 1'b0;
      end
      if (r_state == ST_CAPTURE) begin
        r_res00 <= c00_in;
        r_res01 <= c01_in;
        r_res10 <= c10_in;
        r_res11 <= c11_in;
        r_valid <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (start) w_next = ST_CLEAR;
      ST_CLEAR:   w_next = ST_FEED;
      ST_FEED:    if (r_step == LAST_STEP) w_next = ST_DRAIN;
      ST_DRAIN:   w_next = ST_CAPTURE;
      ST_CAPTURE: w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Zero selects outside FEED flush the PE pipeline registers
  always_comb begin
    w_sel = SEL_ALL_ZERO;
    busy  = (r_state != ST_IDLE);
    clear = (r_state == ST_CLEAR) && !r_accum;
    if (r_state == ST_FEED) w_sel = feed_sel(r_step);
  end

  assign a0_sel       = w_sel.a0;
  assign a1_sel       = w_sel.a1;
  assign b0_sel       = w_sel.b0;
  assign b1_sel       = w_sel.b1;
  assign done         = r_done;
  assign transpose    = r_transpose;
  assign activation   = r_activation;
  assign result00     = r_res00;
  assign result01     = r_res01;
  assign result10     = r_res10;
  assign result11     = r_res11;
  assign result_valid = r_valid;

endmodule

// File: tb/tb_systolic_controller.sv
// Self-checking bench: a behavioural 2x2 array is driven by the controller's
// selects, and results are checked against a direct matrix-product model.
module tb_systolic_controller;

  logic clk = 1'b0;
  logic rst, start, transpose_in, activation_in, accumulate;
  logic busy, done, clear, transpose, activation, result_valid;
  logic [1:0] a0_sel, a1_sel, b0_sel, b1_sel;
  logic signed [15:0] c00_in, c01_in, c10_in, c11_in;
  logic signed [15:0] result00, result01, result10, result11;

  int checks = 0;
  int errors = 0;

  systolic_controller #(.ACC_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .transpose_in(transpose_in),
    .activation_in(activation_in), .accumulate(accumulate), .busy(busy), .done(done),
    .a0_sel(a0_sel), .a1_sel(a1_sel), .b0_sel(b0_sel), .b1_sel(b1_sel),
    .clear(clear), .transpose(transpose), .activation(activation),
    .c00_in(c00_in), .c01_in(c01_in), .c10_in(c10_in), .c11_in(c11_in),
    .result00(result00), .result01(result01), .result10(result10), .result11(result11),
    .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  // Operand memories (row-major) and the array environment model
  int A[2][2];
  int B[2][2];
  int acc[2][2];
  int da0, da1, db0, db1;

  function automatic int op_a(int i, logic [1:0] sel);
    return (sel == 2'd2) ? 0 : A[i][sel];
  endfunction

  function automatic int op_b(int j, logic [1:0] sel, logic tr);
    if (sel == 2'd2) return 0;
    return tr ? B[j][sel] : B[sel][j];
  endfunction

  always @(posedge clk) begin
    int a0, a1, b0, b1;
    a0 = op_a(0, a0_sel); a1 = op_a(1, a1_sel);
    b0 = op_b(0, b0_sel, transpose); b1 = op_b(1, b1_sel, transpose);
    if (rst) begin
      for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) acc[i][j] <= 0;
      da0 <= 0; da1 <= 0; db0 <= 0; db1 <= 0;
    end else begin
      if (clear) begin
        for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) acc[i][j] <= 0;
      end else begin
        acc[0][0] <= acc[0][0] + a0 * b0;
        acc[0][1] <= acc[0][1] + da0 * b1;
        acc[1][0] <= acc[1][0] + a1 * db0;
        acc[1][1] <= acc[1][1] + da1 * db1;
      end
      da0 <= a0; da1 <= a1; db0 <= b0; db1 <= b1;
    end
  end

  function automatic logic signed [15:0] arr_out(int v, logic act);
    return (act && v < 0) ? 16'sd0 : 16'(v);
  endfunction

  always_comb begin
    c00_in = arr_out(acc[0][0], activation);
    c01_in = arr_out(acc[0][1], activation);
    c10_in = arr_out(acc[1][0], activation);
    c11_in = arr_out(acc[1][1], activation);
  end

  // Reference state: accumulated product and last captured results
  int  exp_acc[2][2];
  int  exp_res[4];
  int  prev_res[4];
  bit  cur_acc, cur_tr, cur_act;
  logic [7:0] sel_tab[3] = '{8'h02_0 + 8'h00, 8'h00, 8'h00};

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clip16(int v);
    return int'(shortint'(v));
  endfunction

  // Call at a negedge: raises start with the given command and updates reference
  task automatic launch(input bit tr, input bit act, input bit accm);
    int p;
    for (int r = 0; r < 4; r++) prev_res[r] = exp_res[r];
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        p = 0;
        for (int k = 0; k < 2; k++) p += A[i][k] * (tr ? B[j][k] : B[k][j]);
        exp_acc[i][j] = accm ? exp_acc[i][j] + p : p;
        exp_res[i*2+j] = clip16((act && exp_acc[i][j] < 0) ? 0 : exp_acc[i][j]);
      end
    cur_tr = tr; cur_act = act; cur_acc = accm;
    transpose_in = tr; activation_in = act; accumulate = accm;
    start = 1'b1;
  endtask

  // Follows one operation for cycles n+1..n+7; poke_k raises a stray start
  task automatic track(input int poke_k);
    logic [7:0] exp_sel;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k >= 2 && k <= 4) exp_sel = sel_tab[k-2];
      else exp_sel = 8'hAA;
      chk($sformatf("sel_k%0d", k), {a0_sel, a1_sel, b0_sel, b1_sel}, exp_sel);
      chk($sformatf("busy_k%0d", k), busy, (k <= 6));
      chk($sformatf("done_k%0d", k), done, (k == 7));
      chk($sformatf("clear_k%0d", k), clear, (k == 1) && !cur_acc);
      if (k == 1) chk("rvalid_cleared", result_valid, 0);
      if (k == 3) chk("res00_held", result00, prev_res[0]);
      if (k == 7) begin
        chk("rvalid", result_valid, 1);
        chk("res00", result00, exp_res[0]);
        chk("res01", result01, exp_res[1]);
        chk("res10", result10, exp_res[2]);
        chk("res11", result11, exp_res[3]);
        chk("transpose", transpose, cur_tr);
        chk("activation", activation, cur_act);
      end
      if (k == poke_k) begin
        transpose_in = ~cur_tr; activation_in = ~cur_act; accumulate = ~cur_acc;
        start = 1'b1;
      end
    end
  endtask

  task automatic set_ab(input int a00, a01, a10, a11, b00, b01, b10, b11);
    A[0][0] = a00; A[0][1] = a01; A[1][0] = a10; A[1][1] = a11;
    B[0][0] = b00; B[0][1] = b01; B[1][0] = b10; B[1][1] = b11;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_clear"}, clear, 0);
    chk({tag, "_sel"}, {a0_sel, a1_sel, b0_sel, b1_sel}, 8'hAA);
    chk({tag, "_tr"}, transpose, 0);
    chk({tag, "_act"}, activation, 0);
    chk({tag, "_rvalid"}, result_valid, 0);
    chk({tag, "_res"}, {result00, result01, result10, result11}, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // FEED step table {a0,a1,b0,b1}
    sel_tab[0] = {2'd0, 2'd2, 2'd0, 2'd2};
    sel_tab[1] = {2'd1, 2'd0, 2'd1, 2'd0};
    sel_tab[2] = {2'd2, 2'd1, 2'd2, 2'd1};
    for (int r = 0; r < 4; r++) exp_res[r] = 0;
    for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) exp_acc[i][j] = 0;
    rst = 1'b1; start = 1'b1; transpose_in = 1'b1; activation_in = 1'b1; accumulate = 1'b0;
    set_ab(1, 2, 3, 4, 5, 6, 7, 8);
    idle(2);
    check_reset_outputs("rst_start");
    start = 1'b0; rst = 1'b0;
    idle(1);
    check_reset_outputs("reset");

    launch(0, 0, 0); track(0);
    chk("c1_exp", exp_res[0], 19);
    launch(1, 0, 0); track(0);
    set_ab(-1, 0, 0, 1, 5, 0, 0, -3);
    launch(0, 1, 0); track(0);
    launch(0, 0, 0); track(0);
    set_ab(1, 2, 3, 4, 5, 6, 7, 8);
    launch(0, 0, 0); track(0);
    launch(0, 0, 1); track(0);
    idle(1);

    // Reset in FEED step 1
    launch(0, 0, 0);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_sel", {a0_sel, a1_sel, b0_sel, b1_sel}, sel_tab[1]);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midop");
    rst = 1'b0;
    for (int r = 0; r < 4; r++) exp_res[r] = 0;
    for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) exp_acc[i][j] = 0;
    launch(0, 0, 0); track(0);

    // Stray start while busy, then back-to-back start in the done cycle
    launch(1, 0, 0); track(3);
    launch(0, 0, 0); track(0);
    idle(2);

    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++) begin
          A[i][j] = $urandom_range(40) - 20;
          B[i][j] = $urandom_range(40) - 20;
        end
      launch(1'($urandom_range(1)), 1'($urandom_range(1)), ($urandom_range(3) == 0));
      track(($urandom_range(3) == 0) ? int'($urandom_range(6, 2)) : 0);
      idle($urandom_range(2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end

endmodule
